// File: rtl/fmap_bank_buffer.sv
// fmap_bank_buffer
// ----------------
// N-bank round-robin feature-map buffer. A producer streams tiles into the
// current fill bank; a consumer random-reads the oldest completed bank and
// then releases it. Each bank is one inferred block RAM with a registered
// read port (1-cycle read latency).
//
// Optional feature macro: FMAP_BUF_RELU_EN
//   defined   -> every signed LANE_W lane of i_wr_data is clamped to 0 when
//                negative before it is stored (no extra latency).
//   undefined -> i_wr_data is stored unmodified.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready/i_wr_data/i_wr_last   producer stream
//   o_rd_bank_valid      a completed bank is held for the consumer
//   o_rd_bank_id         index of the held bank
//   o_rd_count           word count of the held bank (0 when none held)
//   i_rd_en/i_rd_addr    read request; o_rd_data/o_rd_data_valid one cycle later
//   i_rd_done            consumer releases the held bank
//   o_err_sticky         protocol error seen since reset
//   o_dbg_bank_state     2-bit state of each bank (bank b at [2b+1:2b])
//
// Handshake: a word transfers on a rising edge where i_wr_valid and
// o_wr_ready are both high; i_wr_last is only meaningful on that edge.
// o_wr_ready depends only on internal state, never on i_wr_valid, so the
// producer may hold i_wr_valid high while waiting.
module fmap_bank_buffer #(
  parameter int LANE_W    = 8,
  parameter int LANES     = 8,
  parameter int DEPTH     = 1024,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = $clog2(DEPTH),
  // derived widths, not meant to be overridden
  parameter int DATA_W    = LANE_W * LANES,
  parameter int CNT_W     = ADDR_W + 1,
  parameter int SEL_W     = $clog2(NUM_BANKS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_wr_last,
  output logic                   o_rd_bank_valid,
  output logic [SEL_W-1:0]       o_rd_bank_id,
  output logic [CNT_W-1:0]       o_rd_count,
  input  logic                   i_rd_en,
  input  logic [ADDR_W-1:0]      i_rd_addr,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic                   o_rd_data_valid,
  input  logic                   i_rd_done,
  output logic                   o_err_sticky,
  output logic [2*NUM_BANKS-1:0] o_dbg_bank_state
);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2,
    B_READING = 2'd3
  } bank_state_t;

  bank_state_t       r_state     [NUM_BANKS];
  bank_state_t       w_state_nxt [NUM_BANKS];
  logic [CNT_W-1:0]  r_count     [NUM_BANKS];
  logic [DATA_W-1:0] w_bank_q    [NUM_BANKS];

  logic [SEL_W-1:0]  r_wr_sel;
  logic [SEL_W-1:0]  r_rd_sel;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_rd_valid;
  logic              r_rd_oob;
  logic [SEL_W-1:0]  r_rd_bank;
  logic              r_err;

  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_wr_close;
  logic              w_rd_held;
  logic              w_rd_ok;
  logic              w_rd_oob;
  logic              w_release;
  logic              w_proto_err;
  logic [DATA_W-1:0] w_wr_word;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NUM_BANKS - 1)) ? '0 : s + SEL_W'(1);
  endfunction

  assign w_wr_ready  = (r_state[r_wr_sel] == B_EMPTY) || (r_state[r_wr_sel] == B_FILLING);
  assign w_wr_fire   = i_wr_valid && w_wr_ready;
  // A tile closes on wr_last or when it fills the bank; the latter is legal.
  assign w_wr_close  = w_wr_fire && (i_wr_last || (r_wr_ptr == ADDR_W'(DEPTH - 1)));

  assign w_rd_held   = (r_state[r_rd_sel] == B_FULL) || (r_state[r_rd_sel] == B_READING);
  assign w_rd_ok     = i_rd_en && w_rd_held;
  assign w_rd_oob    = {1'b0, i_rd_addr} >= r_count[r_rd_sel];
  assign w_release   = i_rd_done && w_rd_held;
  assign w_proto_err = (i_rd_en && !w_rd_held) || (i_rd_done && !w_rd_held) || (w_rd_ok && w_rd_oob);

`ifdef FMAP_BUF_RELU_EN
  always_comb begin
    w_wr_word = i_wr_data;
    for (int l = 0; l < LANES; l++) begin
      if (i_wr_data[l*LANE_W + LANE_W - 1]) w_wr_word[l*LANE_W +: LANE_W] = '0;
    end
  end
`else
  assign w_wr_word = i_wr_data;
`endif

  // Write and read banks are never the same bank while both are active
  // (fill bank is EMPTY/FILLING, read bank is FULL/READING), so a close and
  // a release in the same cycle touch different entries.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_wr_fire && (r_wr_sel == SEL_W'(b)))
        w_state_nxt[b] = w_wr_close ? B_FULL : B_FILLING;
      if (w_rd_ok && (r_rd_sel == SEL_W'(b)) && (r_state[b] == B_FULL))
        w_state_nxt[b] = B_READING;
      if (w_release && (r_rd_sel == SEL_W'(b)))
        w_state_nxt[b] = B_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= B_EMPTY;
        r_count[b] <= '0;
      end
      r_wr_sel   <= '0;
      r_rd_sel   <= '0;
      r_wr_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_rd_bank  <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= w_state_nxt[b];
        if (w_wr_close && (r_wr_sel == SEL_W'(b)))
          r_count[b] <= {1'b0, r_wr_ptr} + CNT_W'(1);
        else if (w_release && (r_rd_sel == SEL_W'(b)))
          r_count[b] <= '0;
      end
      if (w_wr_fire) r_wr_ptr <= w_wr_close ? '0 : r_wr_ptr + ADDR_W'(1);
      if (w_wr_close) r_wr_sel <= next_sel(r_wr_sel);
      if (w_release) r_rd_sel <= next_sel(r_rd_sel);
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_oob  <= w_rd_oob;
        r_rd_bank <= r_rd_sel;
      end
      r_err <= r_err || w_proto_err;
    end
  end

  // One RAM per bank. Contents survive reset. A read in the same cycle as a
  // release still returns the released bank's data since nothing overwrote it.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge i_clk) begin
      if (w_wr_fire && (r_wr_sel == SEL_W'(g))) r_mem[r_wr_ptr] <= w_wr_word;
      if (w_rd_ok && (r_rd_sel == SEL_W'(g))) r_q <= r_mem[i_rd_addr];
    end
    assign w_bank_q[g] = r_q;
  end

  assign o_wr_ready      = w_wr_ready;
  assign o_rd_bank_valid = w_rd_held;
  assign o_rd_bank_id    = r_rd_sel;
  assign o_rd_count      = r_count[r_rd_sel];
  assign o_rd_data_valid = r_rd_valid;
  // Out-of-range reads return zero; idle cycles also show zero.
  assign o_rd_data       = (r_rd_valid && !r_rd_oob) ? w_bank_q[r_rd_bank] : '0;
  assign o_err_sticky    = r_err;

  always_comb begin
    o_dbg_bank_state = '0;
    for (int b = 0; b < NUM_BANKS; b++) o_dbg_bank_state[2*b +: 2] = r_state[b];
  end

endmodule

// File: tb/tb_fmap_bank_buffer.sv
// Testbench for fmap_bank_buffer (DEPTH=16, NUM_BANKS=2, 8x8-bit lanes).
// A tile-level model (held-tile count, fill position, per-bank word arrays)
// predicts every output each cycle; directed sequences pin the model with
// hand-computed literals, then a randomized phase exercises overlap.
module tb_fmap_bank_buffer;
  localparam int DEPTH  = 16;
  localparam int NB     = 2;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_valid = 1'b0, wr_last = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              wr_ready, rd_bank_valid, rd_data_valid, err_sticky;
  logic [0:0]        rd_bank_id;
  logic [CNT_W-1:0]  rd_count;
  logic [DATA_W-1:0] rd_data;
  logic [2*NB-1:0]   dbg_state;

  fmap_bank_buffer #(.LANE_W(8), .LANES(8), .DEPTH(DEPTH), .NUM_BANKS(NB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data), .i_wr_last(wr_last),
    .o_rd_bank_valid(rd_bank_valid), .o_rd_bank_id(rd_bank_id), .o_rd_count(rd_count),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_data_valid(rd_data_valid),
    .i_rd_done(rd_done), .o_err_sticky(err_sticky), .o_dbg_bank_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem [NB][DEPTH];
  int  m_cnt [NB];
  int  m_fill_bank, m_fill_n, m_rd_sel, m_held;
  int  m_rel, m_cls;
  bit  m_err, m_rd_valid, m_live = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] relu_ref(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
`ifdef FMAP_BUF_RELU_EN
    for (int l = 0; l < 8; l++) begin
      logic [7:0] lane;
      lane = w[l*8 +: 8];
      if ($signed(lane) < 0) r[l*8 +: 8] = 8'h00;
    end
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_fill_bank = 0; m_fill_n = 0; m_rd_sel = 0; m_held = 0;
      for (int b = 0; b < NB; b++) m_cnt[b] = 0;
      m_err = 1'b0; m_rd_valid = 1'b0; m_live = 1'b1;
      exp_q.delete();
    end else if (m_live) begin
      m_rel = 0; m_cls = 0; m_rd_valid = 1'b0;
      if (rd_en) begin
        if (m_held > 0) begin
          m_rd_valid = 1'b1;
          if (int'(rd_addr) < m_cnt[m_rd_sel]) exp_q.push_back(m_mem[m_rd_sel][rd_addr]);
          else begin exp_q.push_back('0); m_err = 1'b1; end
        end else m_err = 1'b1;
      end
      if (rd_done) begin
        if (m_held > 0) m_rel = 1; else m_err = 1'b1;
      end
      if (wr_valid && m_held < NB) begin
        m_mem[m_fill_bank][m_fill_n] = relu_ref(wr_data);
        m_fill_n++;
        if (wr_last || m_fill_n == DEPTH) m_cls = 1;
      end
      if (m_rel == 1) begin
        m_cnt[m_rd_sel] = 0;
        m_rd_sel = (m_rd_sel + 1) % NB;
      end
      if (m_cls == 1) begin
        m_cnt[m_fill_bank] = m_fill_n;
        m_fill_bank = (m_fill_bank + 1) % NB;
        m_fill_n = 0;
      end
      m_held = m_held + m_cls - m_rel;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("wr_ready", 64'(wr_ready), 64'(m_held < NB));
      check("rd_bank_valid", 64'(rd_bank_valid), 64'(m_held > 0));
      check("rd_bank_id", 64'(rd_bank_id), 64'(m_rd_sel));
      check("rd_count", 64'(rd_count), (m_held > 0) ? 64'(m_cnt[m_rd_sel]) : 64'd0);
      check("err_sticky", 64'(err_sticky), 64'(m_err));
      check("rd_data_valid", 64'(rd_data_valid), 64'(m_rd_valid));
      if (m_rd_valid && exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [63:0] d, input bit l,
                       input bit re, input int a, input bit dn);
    wr_valid = v; wr_data = d; wr_last = l;
    rd_en = re; rd_addr = ADDR_W'(a); rd_done = dn;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
    check({tag, "_rd_bank_valid"}, 64'(rd_bank_valid), 64'd0);
    check({tag, "_rd_bank_id"}, 64'(rd_bank_id), 64'd0);
    check({tag, "_rd_count"}, 64'(rd_count), 64'd0);
    check({tag, "_rd_data"}, rd_data, 64'd0);
    check({tag, "_rd_data_valid"}, 64'(rd_data_valid), 64'd0);
    check({tag, "_err"}, 64'(err_sticky), 64'd0);
  endtask

  logic [63:0] relu_exp;
  bit v_r, l_r, re_r, dn_r;
  int a_r;

  initial begin
    do_reset();
    check_reset_outputs("rst");

    // 10-word tile with wr_last
    for (int i = 1; i <= 10; i++) drive(1, 64'(i), i == 10, 0, 0, 0);
    check("t1_valid", 64'(rd_bank_valid), 64'd1);
    check("t1_id", 64'(rd_bank_id), 64'd0);
    check("t1_count", 64'(rd_count), 64'd10);
    drive(0, '0, 0, 1, 3, 0);
    check("t1_rdv", 64'(rd_data_valid), 64'd1);
    check("t1_rd3", rd_data, 64'h04);

    // out-of-range read
    drive(0, '0, 0, 1, 12, 0);
    check("oob_rdv", 64'(rd_data_valid), 64'd1);
    check("oob_data", rd_data, 64'd0);
    check("oob_err", 64'(err_sticky), 64'd1);
    check("oob_held", 64'(rd_bank_valid), 64'd1);
    check("oob_count", 64'(rd_count), 64'd10);
    drive(0, '0, 0, 0, 0, 1);
    check("rel_valid", 64'(rd_bank_valid), 64'd0);
    check("rel_id", 64'(rd_bank_id), 64'd1);

    // read with no held bank
    do_reset();
    drive(0, '0, 0, 1, 0, 0);
    check("noheld_rdv", 64'(rd_data_valid), 64'd0);
    check("noheld_err", 64'(err_sticky), 64'd1);
    check("noheld_valid", 64'(rd_bank_valid), 64'd0);

    // release with no held bank
    do_reset();
    drive(0, '0, 0, 0, 0, 1);
    check("idledone_err", 64'(err_sticky), 64'd1);
    check("idledone_valid", 64'(rd_bank_valid), 64'd0);
    check("idledone_id", 64'(rd_bank_id), 64'd0);
    check("idledone_wr_ready", 64'(wr_ready), 64'd1);

    // two auto-closed tiles fill both banks
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 64'h100 + 64'(i), 0, 0, 0, 0);
      if (i == 15) check("auto1_wr_ready", 64'(wr_ready), 64'd1);
    end
    check("full_wr_ready", 64'(wr_ready), 64'd0);
    check("full_count", 64'(rd_count), 64'd16);
    idle();
    check("full_wr_ready2", 64'(wr_ready), 64'd0);
    drive(0, '0, 0, 0, 0, 1);
    check("after_rel_wr_ready", 64'(wr_ready), 64'd1);
    check("after_rel_id", 64'(rd_bank_id), 64'd1);
    check("after_rel_count", 64'(rd_count), 64'd16);
    drive(0, '0, 0, 1, 5, 0);
    check("bank1_rd5", rd_data, 64'h115);
    check("auto_err", 64'(err_sticky), 64'd0);

    // read bank 0 while bank 1 fills at full rate
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, {$urandom, $urandom}, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, {$urandom, $urandom}, 0, 1, i, i == 15);
      check("overlap_wr_ready", 64'(wr_ready), 64'd1);
    end
    check("overlap_id", 64'(rd_bank_id), 64'd1);

    // reset while bank 0 is READING and bank 1 is FILLING
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 64'h50 + 64'(i), i == 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 64'h60 + 64'(i), 0, 1, i, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check_reset_outputs("midrst");
    drive(1, 64'hAA, 0, 0, 0, 0);
    drive(1, 64'hBB, 1, 0, 0, 0);
    check("newtile_id", 64'(rd_bank_id), 64'd0);
    check("newtile_count", 64'(rd_count), 64'd2);
    drive(0, '0, 0, 1, 1, 0);
    check("newtile_rd1", rd_data, 64'hBB);

    // lane values 0x85 and 0x7F (ReLU clamps 0x85 only when enabled)
    drive(0, '0, 0, 0, 0, 1);
    drive(1, 64'h7F857F857F857F85, 1, 0, 0, 0);
    check("relu_id", 64'(rd_bank_id), 64'd1);
    drive(0, '0, 0, 1, 0, 0);
`ifdef FMAP_BUF_RELU_EN
    relu_exp = 64'h7F007F007F007F00;
`else
    relu_exp = 64'h7F857F857F857F85;
`endif
    check("relu_rd", rd_data, relu_exp);

    // randomized phase
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v_r  = $urandom_range(0, 3) != 0;
      l_r  = $urandom_range(0, 7) == 0;
      re_r = (m_held > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 63) == 0);
      a_r  = (m_held > 0 && $urandom_range(0, 63) != 0) ? $urandom_range(0, m_cnt[m_rd_sel] - 1)
                                                         : $urandom_range(0, DEPTH - 1);
      dn_r = (m_held > 0) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 127) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      drive(v_r, {$urandom, $urandom}, l_r, re_r, a_r, dn_r);
    end
    rst = 1'b0;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmap_bank_buffer.md
Name: fmap_bank_buffer

Overview:
- Parametrised N-bank ping-pong feature-map buffer for the CNN accelerator. It generalises the fixed two-instance Conv2 double-buffer pair into one self-contained block.
- The producer side (PE output / pooling stage) streams a tile into the current fill bank through a valid/ready handshake.
- The consumer side (next conv layer) random-reads a completed bank, then releases it.
- Storage is inferred BRAM inside the block, one array per bank, with 1-cycle read latency.

Parameters:
- LANE_W, 8, bits per signed activation lane.
- LANES, 8, lanes per word; word width DATA_W = LANE_W*LANES (64 default).
- DEPTH, 1024, words per bank; power of two, 16 to 4096.
- NUM_BANKS, 2, number of banks, 2 to 4; banks are filled and read in round-robin order.
- ADDR_W, $clog2(DEPTH), address width; CNT_W = ADDR_W+1.

Ports:
- clk  in  1  system clock (clk_wiz output domain).
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  producer word valid.
- wr_ready  out  1  block can accept a word this cycle.
- wr_data  in  DATA_W  producer word.
- wr_last  in  1  last word of tile; qualified by wr_valid&wr_ready.
- rd_bank_valid  out  1  a full bank is held for the consumer.
- rd_bank_id  out  $clog2(NUM_BANKS)  index of the held bank.
- rd_count  out  CNT_W  word count of the held bank.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read word address.
- rd_data  out  DATA_W  read word, registered.
- rd_data_valid  out  1  rd_data valid this cycle.
- rd_done  in  1  consumer releases the held bank.
- err_sticky  out  1  protocol error seen; cleared only by rst.

Behaviour:
- Clocking and reset: single clk; synchronous active-high rst.
- Reset values: every bank EMPTY; wr_sel=0, rd_sel=0, wr_ptr=0; all bank counts 0. Outputs: wr_ready=1, rd_bank_valid=0, rd_bank_id=0, rd_count=0, rd_data=0, rd_data_valid=0, err_sticky=0.
- Reset mid-operation: any tile being filled or read is discarded. RAM contents are not cleared.
- Per-bank state: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Write side:
  - wr_ready = 1 when bank[wr_sel] is EMPTY or FILLING.
  - On an accepted word (wr_valid & wr_ready): RAM[wr_sel][wr_ptr] <= wr_data; the bank goes to FILLING; wr_ptr increments.
  - Bank close happens on an accepted word with wr_last=1, or with wr_ptr==DEPTH-1 (auto-close). On close: count = wr_ptr+1; the bank goes to FULL; wr_ptr=0; wr_sel advances mod NUM_BANKS.
  - If the next bank is not EMPTY, wr_ready drops to 0 in the following cycle.
  - An auto-close without wr_last is not an error. A following word starts a new tile in the next bank.
- Read side:
  - rd_bank_valid = 1 when bank[rd_sel] is FULL or READING.
  - rd_bank_id = rd_sel; rd_count = count[rd_sel].
  - The first rd_en moves the bank FULL -> READING.
  - rd_en with rd_bank_valid: one cycle later rd_data = RAM[rd_sel][rd_addr] and rd_data_valid=1.
  - rd_addr >= rd_count: rd_data = 0, rd_data_valid=1, err_sticky set.
  - rd_en with rd_bank_valid=0: ignored, rd_data_valid=0, err_sticky set.
  - Back-to-back reads are allowed every cycle.
  - rd_done with rd_bank_valid=1: the bank goes to EMPTY and rd_sel advances mod NUM_BANKS. rd_bank_valid reflects the next bank in the following cycle.
  - rd_done with rd_bank_valid=0: ignored, err_sticky set.
  - rd_en and rd_done in the same cycle: the read completes from the released bank, because RAM contents are untouched.
- Simultaneous events:
  - Close and release on different banks in one cycle are both applied.
  - When the writer waits on bank X and the reader releases X in the same cycle, wr_ready rises the next cycle. There is no same-cycle bypass.
- Throughput: the writer sustains 1 word/cycle while a free bank exists. With NUM_BANKS=2, filling overlaps reading.

Optional Feature:
- Macro FMAP_BUF_RELU_EN.
- When defined: each LANE_W lane of wr_data is treated as signed, and negative lanes are written as 0 (ReLU on write). There is no added latency.
- When undefined: wr_data is stored unmodified.

Test Plan:
- DEPTH=16, NUM_BANKS=2; write 10 words 0x01..0x0A with wr_last on the 10th -> rd_bank_valid=1, rd_bank_id=0, rd_count=10; rd_addr=3 returns 0x04 one cycle after rd_en.
- Write 16 words without wr_last, then 16 more -> both banks FULL with rd_count=16; wr_ready=0 from the cycle after the 32nd word; rd_done -> wr_ready=1 next cycle, rd_bank_id=1.
- Read bank 0 while writing bank 1 continuously -> no wr_ready deassertion; all reads match written data.
- Errors: rd_en with no held bank, rd_addr=12 when rd_count=10, and rd_done when idle -> rd_data=0 where applicable, err_sticky=1, and no state change.
- Assert rst while bank 0 is READING and bank 1 is FILLING -> all outputs return to reset values the next cycle; a new tile starts in bank 0.
- FMAP_BUF_RELU_EN defined; write lane values 0x85 and 0x7F -> read back 0x00 and 0x7F. Undefined -> read back 0x85 and 0x7F.
